// File: rtl/tt_sweep_pkg.sv
// Shared constants and types for the truth-table sweep collector.
// Optional onset counting is enabled by TT_SWEEP_ONSET_COUNT_EN (see tt_sweep_collector).
package tt_sweep_pkg;

  localparam int unsigned TT_N_IN = 7;
  localparam int unsigned TT_W    = 1 << TT_N_IN;

  typedef logic [TT_N_IN-1:0] tt_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } tt_state_e;

endpackage

// File: rtl/tt_lat_shift.sv
// Delays the (issue enable, index) pair by Lat cycles so the capture lines up with the
// function network's latency; a plain wire when Lat is zero.
module tt_lat_shift #(
  parameter int unsigned Lat  = 0,
  parameter int unsigned IdxW = 7
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [IdxW-1:0] idx_i,
  output logic            en_o,
  output logic [IdxW-1:0] idx_o
);

  if (Lat == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
    assign en_o  = en_i;
    assign idx_o = idx_i;
  end else begin : g_pipe
    logic [Lat-1:0]  en_q;
    logic [IdxW-1:0] idx_q [Lat];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        en_q <= '0;
        for (int unsigned i = 0; i < Lat; i++) begin
          idx_q[i] <= '0;
        end
      end else begin
        en_q[0]  <= en_i;
        idx_q[0] <= idx_i;
        for (int unsigned i = 1; i < Lat; i++) begin
          en_q[i]  <= en_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign en_o  = en_q[Lat-1];
    assign idx_o = idx_q[Lat-1];
  end

endmodule

// File: rtl/tt_sweep_collector.sv
// Sweeps all 2**N_IN input vectors through a Boolean network and assembles its truth table.
// Define TT_SWEEP_ONSET_COUNT_EN to add the onset_cnt (table popcount) output.
module tt_sweep_collector
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN     = TT_N_IN,
  parameter int unsigned FUNC_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [N_IN-1:0]         x_vec,
  input  logic                    func_out,
  output logic                    busy,
  output logic                    tt_valid,
  input  logic                    tt_ready,
  output logic [(1 << N_IN)-1:0]  tt_data
`ifdef TT_SWEEP_ONSET_COUNT_EN
  ,
  output logic [N_IN:0]           onset_cnt
`endif
);

  localparam int unsigned TtW = 1 << N_IN;

  tt_state_e        state_q;
  logic [N_IN:0]    cnt_q;
  logic             busy_q;
  logic             valid_q;
  logic [TtW-1:0]   tt_data_q;

  logic             issue_en;
  logic             issue_last;
  logic [N_IN-1:0]  issue_idx;
  logic             cap_en;
  logic             cap_last;
  logic [N_IN-1:0]  cap_idx;
  logic             sweep_entry;

  assign issue_en    = (state_q == StSweep);
  assign issue_idx   = cnt_q[N_IN-1:0];
  assign issue_last  = issue_en && (&issue_idx);
  assign cap_last    = cap_en && (&cap_idx);
  assign sweep_entry = (state_q == StIdle) && start;

  tt_lat_shift #(
    .Lat  (FUNC_LAT),
    .IdxW (N_IN)
  ) u_lat_shift (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (issue_en),
    .idx_i (issue_idx),
    .en_o  (cap_en),
    .idx_o (cap_idx)
  );

  // The counter is held at zero outside SWEEP, so it can drive x_vec directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSweep;
            busy_q  <= 1'b1;
          end
        end
        StSweep: begin
          if (issue_last) begin
            cnt_q <= '0;
            if (cap_last) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end else begin
            cnt_q <= cnt_q + (N_IN+1)'(1);
          end
        end
        StDrain: begin
          if (cap_last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (tt_ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_data_q <= '0;
    end else if (sweep_entry) begin
      tt_data_q <= '0;
    end else if (cap_en) begin
      tt_data_q[cap_idx] <= func_out;
    end
  end

`ifdef TT_SWEEP_ONSET_COUNT_EN
  logic [N_IN:0] onset_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      onset_q <= '0;
    end else if (sweep_entry) begin
      onset_q <= '0;
    end else if (cap_en) begin
      onset_q <= onset_q + (N_IN+1)'(func_out);
    end
  end

  assign onset_cnt = onset_q;
`endif

  assign x_vec    = cnt_q[N_IN-1:0];
  assign busy     = busy_q;
  assign tt_valid = valid_q;
  assign tt_data  = tt_data_q;

endmodule

// File: tb/tb_tt_sweep_collector.sv
// Scoreboard bench: one collector with a combinational function, one with a 2-cycle model.
module tb_tt_sweep_collector;

  typedef struct {
    logic [127:0] data;
    int           lat;
    logic [7:0]   onset;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start_s [2];
  logic         ready_s [2];
  logic         busy_s  [2];
  logic         valid_s [2];
  logic [6:0]   xv_s    [2];
  logic [127:0] data_s  [2];
  logic [7:0]   onset_s [2];
  int unsigned  fsel    [2];
  logic         func0;
  logic         func1;
  logic         p1;
  logic         p2;
  logic         vprev   [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb0[$];
  exp_t sb1[$];

  localparam logic [127:0] ExpMaj  = {16{8'hE8}};
  localparam logic [127:0] ExpX6   = {{64{1'b1}}, {64{1'b0}}};
  localparam logic [127:0] ExpOdd  = {16{8'hAA}};
  localparam logic [127:0] ExpOnes = {128{1'b1}};

  function automatic logic fmodel(input int unsigned m, input logic [6:0] x);
    case (m)
      0:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      1:       return x[6];
      2:       return 1'b0;
      3:       return 1'b1;
      default: return x[0];
    endcase
  endfunction

  assign func0 = fmodel(fsel[0], xv_s[0]);
  assign func1 = p2;

  always @(posedge clk) begin
    p1 <= fmodel(fsel[1], xv_s[1]);
    p2 <= p1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tt_sweep_collector #(.N_IN(7), .FUNC_LAT(0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s[0]),
    .x_vec    (xv_s[0]),
    .func_out (func0),
    .busy     (busy_s[0]),
    .tt_valid (valid_s[0]),
    .tt_ready (ready_s[0]),
    .tt_data  (data_s[0])
`ifdef TT_SWEEP_ONSET_COUNT_EN
    ,
    .onset_cnt (onset_s[0])
`endif
  );

  tt_sweep_collector #(.N_IN(7), .FUNC_LAT(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start_s[1]),
    .x_vec    (xv_s[1]),
    .func_out (func1),
    .busy     (busy_s[1]),
    .tt_valid (valid_s[1]),
    .tt_ready (ready_s[1]),
    .tt_data  (data_s[1])
`ifdef TT_SWEEP_ONSET_COUNT_EN
    ,
    .onset_cnt (onset_s[1])
`endif
  );

`ifndef TT_SWEEP_ONSET_COUNT_EN
  initial begin
    onset_s[0] = '0;
    onset_s[1] = '0;
  end
`endif

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t sb_front(input int i);
    return (i == 0) ? sb0[0] : sb1[0];
  endfunction

  // Monitor: latency on tt_valid rise, content on each accepted transfer.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && valid_s[i] && !vprev[i]) begin
        if (sb_size(i) == 0) begin
          check($sformatf("unexpected_table%0d", i), 128'(valid_s[i]), 128'd0);
        end else begin
          check($sformatf("valid_latency%0d", i), 128'(cyc - sb_front(i).cyc),
                128'(sb_front(i).lat));
        end
      end
      if (!rst && valid_s[i] && ready_s[i] && sb_size(i) != 0) begin
        check($sformatf("tt_data%0d", i), data_s[i], sb_front(i).data);
`ifdef TT_SWEEP_ONSET_COUNT_EN
        check($sformatf("onset_cnt%0d", i), 128'(onset_s[i]), 128'(sb_front(i).onset));
`endif
        if (i == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
      end
      vprev[i] = valid_s[i];
    end
  end

  // Called 1 time unit after a rising edge; the start cycle is the current cycle.
  task automatic kick(input int i, input int unsigned mode, input logic [127:0] d,
                      input int lat, input logic [7:0] on);
    exp_t e;
    fsel[i] = mode;
    e.data  = d;
    e.lat   = lat;
    e.onset = on;
    e.cyc   = cyc;
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    start_s[i] = 1'b1;
    @(posedge clk);
    #1 start_s[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    logic seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (valid_s[i]) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("valid_wait%0d", i), 128'(seen), 128'd1);
  endtask

  task automatic wait_xfer(input int i);
    logic seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (valid_s[i] && ready_s[i]) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("xfer_wait%0d", i), 128'(seen), 128'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    ready_s[0] = 1'b1;
    ready_s[1] = 1'b1;
    fsel[0]    = 0;
    fsel[1]    = 0;
    vprev[0]   = 1'b0;
    vprev[1]   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_xvec%0d", i), 128'(xv_s[i]), 128'd0);
      check($sformatf("rst_busy%0d", i), 128'(busy_s[i]), 128'd0);
      check($sformatf("rst_valid%0d", i), 128'(valid_s[i]), 128'd0);
      check($sformatf("rst_data%0d", i), data_s[i], 128'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: majority, combinational network
    kick(0, 0, ExpMaj, 129, 8'd64);
    check("sweep_busy", 128'(busy_s[0]), 128'd1);
    wait_xfer(0);

    // 2: f = x6 through the 2-cycle model
    kick(1, 1, ExpX6, 131, 8'd64);
    wait_xfer(1);

    // 3: all-zero then all-one tables back to back
    kick(0, 2, 128'd0, 129, 8'd0);
    wait_xfer(0);
    kick(0, 3, ExpOnes, 129, 8'd128);
    wait_xfer(0);

    // 4: downstream stalls 20 cycles; start in the transfer cycle is dropped
    ready_s[0] = 1'b0;
    kick(0, 0, ExpMaj, 129, 8'd64);
    wait_valid(0);
    repeat (20) begin
      @(negedge clk);
      check("stall_valid", 128'(valid_s[0]), 128'd1);
      check("stall_data", data_s[0], ExpMaj);
    end
    @(posedge clk);
    #1;
    ready_s[0] = 1'b1;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    check("post_xfer_busy", 128'(busy_s[0]), 128'd0);
    check("post_xfer_valid", 128'(valid_s[0]), 128'd0);
    @(posedge clk);
    #1;
    check("ignored_start_busy", 128'(busy_s[0]), 128'd0);

    // 5: reset 50 cycles into an all-ones sweep, then a fresh x0 sweep
    fsel[0]    = 3;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_xvec", 128'(xv_s[0]), 128'd0);
    check("abort_busy", 128'(busy_s[0]), 128'd0);
    check("abort_valid", 128'(valid_s[0]), 128'd0);
    kick(0, 4, ExpOdd, 129, 8'd64);
    wait_xfer(0);

    // 6: start pulses during SWEEP and DONE yield a single table
    ready_s[0] = 1'b0;
    kick(0, 1, ExpX6, 129, 8'd64);
    repeat (9) @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    wait_valid(0);
    @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 ready_s[0] = 1'b1;
    wait_xfer(0);
    repeat (10) begin
      @(negedge clk);
      check("single_table_busy", 128'(busy_s[0]), 128'd0);
      check("single_table_valid", 128'(valid_s[0]), 128'd0);
    end

    check("sb0_drained", 128'(sb0.size()), 128'd0);
    check("sb1_drained", 128'(sb1.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
